byte_ram: RTL and testbench

- Byte-addressable, single-clock read/write data memory for the RV32I core.
- Covers the byte address window START_ADDRESS..STOP_ADDRESS inclusive.
- Each access moves 1, 2, 3 or 4 bytes at any byte address, little-endian.
- Sits on the core's load/store path; the load/store unit supplies absolute 32-bit byte addresses.

---
 rtl/byte_ram.sv | 72 +++++++
 tb/tb_byte_ram.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/byte_ram.sv
// Byte-addressable data RAM over [START_ADDRESS, STOP_ADDRESS]: 1-4 byte little-endian accesses at any alignment.
// Latency: writes commit on the strobe edge; reads return one cycle later (read-before-write); no backpressure.
module byte_ram #(
    parameter int unsigned START_ADDRESS = 1024,
    parameter int unsigned STOP_ADDRESS  = START_ADDRESS + 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wr_addr,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic [1:0]  by_wlen,
    input  logic [31:0] rd_addr,
    input  logic        rd_en,
    input  logic [1:0]  by_rlen,
    output logic [31:0] rd_data
);

    localparam int unsigned DEPTH = STOP_ADDRESS - START_ADDRESS + 1;
    localparam int unsigned IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]      r_mem [DEPTH];
    logic [31:0]     r_rd_data;

    logic [31:0]     w_wofs [4];
    logic [31:0]     w_rofs [4];
    logic [IDXW-1:0] w_widx [4];
    logic [IDXW-1:0] w_ridx [4];
    logic [3:0]      w_wbe;
    logic [3:0]      w_rbe;
    logic [31:0]     w_rd_next;

    // Offsets are taken modulo 2^32, so an address below the window wraps to a
    // huge offset and a single unsigned compare rejects both ends.
    always_comb begin
        w_wbe     = '0;
        w_rbe     = '0;
        w_rd_next = '0;
        for (int k = 0; k < 4; k++) begin
            w_wofs[k] = wr_addr + 32'(k) - 32'(START_ADDRESS);
            w_rofs[k] = rd_addr + 32'(k) - 32'(START_ADDRESS);
            w_widx[k] = w_wofs[k][IDXW-1:0];
            w_ridx[k] = w_rofs[k][IDXW-1:0];
            w_wbe[k]  = wr_en && (2'(k) <= by_wlen) && (w_wofs[k] < 32'(DEPTH));
            w_rbe[k]  = (2'(k) <= by_rlen) && (w_rofs[k] < 32'(DEPTH));
            if (w_rbe[k]) begin
                w_rd_next[8*k +: 8] = r_mem[w_ridx[k]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= 8'h00;
            end
            r_rd_data <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_wbe[k]) begin
                    r_mem[w_widx[k]] <= wr_data[8*k +: 8];
                end
            end
            if (rd_en) begin
                r_rd_data <= w_rd_next;
            end
        end
    end

    assign rd_data = r_rd_data;

endmodule

// File: tb/tb_byte_ram.sv
// Self-checking bench for byte_ram: directed table, sweeps, reset corner cases, then model-checked random traffic.
module tb_byte_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wr_addr;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [1:0]  by_wlen;
    logic [31:0] rd_addr;
    logic        rd_en;
    logic [1:0]  by_rlen;
    logic [31:0] rd_data;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_q [$];
    string       name_q [$];
    logic [7:0]  mdl [32];

    typedef struct {
        bit          we;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [1:0]  wl;
        bit          re;
        logic [31:0] ra;
        logic [1:0]  rl;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [19];

    byte_ram #(.START_ADDRESS(1024), .STOP_ADDRESS(1055)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_addr (wr_addr),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .by_wlen (by_wlen),
        .rd_addr (rd_addr),
        .rd_en   (rd_en),
        .by_rlen (by_rlen),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mdl_read(input logic [31:0] ra, input logic [1:0] rl);
        logic [31:0] r;
        logic [31:0] a;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            a = ra + 32'(k);
            if (k <= int'(rl) && a >= 32'd1024 && a <= 32'd1055) begin
                r[8*k +: 8] = mdl[int'(a - 32'd1024)];
            end
        end
        return r;
    endfunction

    task automatic mdl_write(input logic [31:0] wa, input logic [31:0] wd, input logic [1:0] wl);
        logic [31:0] a;
        for (int k = 0; k < 4; k++) begin
            a = wa + 32'(k);
            if (k <= int'(wl) && a >= 32'd1024 && a <= 32'd1055) begin
                mdl[int'(a - 32'd1024)] = wd[8*k +: 8];
            end
        end
    endtask

    task automatic check_pop();
        logic [31:0] e;
        string       nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_cmp++;
        if (rd_data !== e) begin
            n_bad++;
            $display("FAIL %s: rd_data=%08h expected=%08h", nm, rd_data, e);
        end
    endtask

    // One clock with the given access; rd_data is checked against exp after the edge.
    task automatic cycle(input bit we, input logic [31:0] wa, input logic [31:0] wd, input logic [1:0] wl,
                         input bit re, input logic [31:0] ra, input logic [1:0] rl,
                         input logic [31:0] exp, input string nm);
        rst     = 1'b0;
        wr_en   = we;  wr_addr = wa; wr_data = wd; by_wlen = wl;
        rd_en   = re;  rd_addr = ra; by_rlen = rl;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        check_pop();
    endtask

    task automatic do_reset(input string nm);
        rst     = 1'b1;
        wr_en   = 1'b1; wr_addr = 32'd1044; wr_data = 32'hFFFF_FFFF; by_wlen = 2'd3;
        rd_en   = 1'b1; rd_addr = 32'd1028; by_rlen = 2'd3;
        exp_q.push_back(32'h0);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        check_pop();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = 8'h00;
    endtask

    initial begin
        logic [31:0] hold;
        logic [31:0] ra, wa, wd, e;
        logic [1:0]  rl, wl;
        bit          we, re;

        vecs[0]  = '{1, 32'd1024, 32'h1234_5678, 3, 0, 32'd0,    0, 32'h0000_00BE};
        vecs[1]  = '{0, 32'd0,    32'h0,         0, 1, 32'd1024, 3, 32'h1234_5678};
        vecs[2]  = '{0, 32'd0,    32'h0,         0, 1, 32'd1027, 0, 32'h0000_0012};
        vecs[3]  = '{1, 32'd1026, 32'hCAFE_F00D, 3, 0, 32'd0,    0, 32'h0000_0012};
        vecs[4]  = '{0, 32'd0,    32'h0,         0, 1, 32'd1026, 3, 32'hCAFE_F00D};
        vecs[5]  = '{0, 32'd0,    32'h0,         0, 1, 32'd1024, 3, 32'hF00D_5678};
        vecs[6]  = '{0, 32'd0,    32'h0,         0, 1, 32'd1024, 2, 32'h000D_5678};
        vecs[7]  = '{1, 32'd1053, 32'h1122_3344, 3, 0, 32'd0,    0, 32'h000D_5678};
        vecs[8]  = '{0, 32'd0,    32'h0,         0, 1, 32'd1053, 3, 32'h0022_3344};
        vecs[9]  = '{0, 32'd0,    32'h0,         0, 1, 32'd1052, 3, 32'h2233_44EF};
        vecs[10] = '{1, 32'd1000, 32'hDEAD_BEEF, 3, 1, 32'd1000, 3, 32'h0000_0000};
        vecs[11] = '{0, 32'd0,    32'h0,         0, 1, 32'd1024, 3, 32'hF00D_5678};
        vecs[12] = '{1, 32'd1022, 32'hAABB_CCDD, 3, 0, 32'd0,    0, 32'hF00D_5678};
        vecs[13] = '{0, 32'd0,    32'h0,         0, 1, 32'd1024, 1, 32'h0000_AABB};
        vecs[14] = '{0, 32'd0,    32'h0,         0, 1, 32'hFFFF_FFFE, 3, 32'h0000_0000};
        vecs[15] = '{1, 32'd1040, 32'h9988_7766, 0, 0, 32'd0,    0, 32'h0000_0000};
        vecs[16] = '{0, 32'd0,    32'h0,         0, 1, 32'd1040, 1, 32'h0000_BE66};
        vecs[17] = '{1, 32'd1028, 32'h5566_7788, 3, 1, 32'd1028, 3, 32'hBEEF_CAFE};
        vecs[18] = '{0, 32'd0,    32'h0,         0, 1, 32'd1028, 3, 32'h5566_7788};

        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; wr_data = '0; by_wlen = '0; rd_addr = '0; by_rlen = '0;
        @(negedge clk);
        do_reset("reset_rd_data");

        for (int a = 1024; a <= 1055; a++) begin
            cycle(0, 0, 0, 0, 1, 32'(a), 0, 32'h0, $sformatf("reset_byte_%0d", a));
        end

        cycle(1, 32'd1030, 32'h7777_77A5, 0, 0, 0, 0, 32'h0, "byte_write_hold");
        cycle(0, 0, 0, 0, 1, 32'd1030, 0, 32'h0000_00A5, "byte_read_1030");
        cycle(0, 0, 0, 0, 1, 32'd1029, 0, 32'h0000_0000, "byte_read_1029");

        for (int a = 1024; a <= 1054; a += 2) begin
            cycle(1, 32'(a), 32'h5555_BEEF, 1, 0, 0, 0, 32'h0, $sformatf("half_write_%0d", a));
        end
        for (int a = 1024; a <= 1054; a += 2) begin
            cycle(0, 0, 0, 0, 1, 32'(a), 1, 32'h0000_BEEF, $sformatf("half_read_%0d", a));
        end
        cycle(0, 0, 0, 0, 1, 32'd1025, 0, 32'h0000_00BE, "half_byte_1025");

        for (int i = 0; i < 19; i++) begin
            cycle(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].wl,
                  vecs[i].re, vecs[i].ra, vecs[i].rl, vecs[i].exp, $sformatf("vec_%0d", i));
        end

        do_reset("midreset_rd_data");
        cycle(0, 0, 0, 0, 0, 0, 0, 32'h0, "midreset_hold");
        for (int a = 1024; a <= 1052; a += 4) begin
            cycle(0, 0, 0, 0, 1, 32'(a), 3, 32'h0, $sformatf("midreset_word_%0d", a));
        end

        hold = 32'h0;
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            wa = 32'($urandom_range(1016, 1063));
            ra = 32'($urandom_range(1016, 1063));
            wd = $urandom;
            wl = 2'($urandom_range(0, 3));
            rl = 2'($urandom_range(0, 3));
            e  = re ? mdl_read(ra, rl) : hold;
            hold = e;
            if (we) mdl_write(wa, wd, wl);
            cycle(we, wa, wd, wl, re, ra, rl, e, $sformatf("rand_%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
